// File: rtl/product_accumulator.sv
// Purpose: sums COUNT consecutive unsigned 16-bit products into one ACC_W-bit result with a sticky overflow flag.
// Latency: out_valid rises the cycle after the COUNT-th accepted product; at most one result per COUNT+1 cycles.
// Backpressure: in_ready drops while a result waits; sum/ovf hold until out_ready. Macro PRODUCT_ACCUMULATOR_SATURATE_EN selects clamping instead of wrapping.
module product_accumulator #(
    parameter int COUNT = 8,
    parameter int ACC_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [ACC_W-1:0] r_sum;
    logic [ACC_W-1:0] w_sum_nxt;
    logic             r_ovf_acc;
    logic             w_ovf_acc_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;

    // One extra bit catches the carry out of the accumulator.
    logic [ACC_W:0]   w_add;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_add;

    assign w_add   = {1'b0, r_acc} + (ACC_W + 1)'(m);
    assign w_carry = w_add[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // Once clamped, any further non-zero product carries again, so the value stays pinned at all-ones.
    assign w_acc_add = w_carry ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
`else
    assign w_acc_add = w_add[ACC_W-1:0];
`endif

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign ovf       = r_ovf;

    // Next-state and datapath update; clear overrides both states and drops any product offered with it.
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_sum_nxt     = r_sum;
        w_ovf_acc_nxt = r_ovf_acc;
        w_ovf_nxt     = r_ovf;
        if (clear) begin
            w_state_nxt   = ST_ACCUM;
            w_acc_nxt     = '0;
            w_cnt_nxt     = '0;
            w_ovf_acc_nxt = 1'b0;
            w_ovf_nxt     = 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        if (r_cnt == LAST_IDX) begin
                            w_sum_nxt   = w_acc_add;
                            w_ovf_nxt   = r_ovf_acc | w_carry;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_acc_nxt     = w_acc_add;
                            w_cnt_nxt     = r_cnt + 8'd1;
                            w_ovf_acc_nxt = r_ovf_acc | w_carry;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_state_nxt   = ST_ACCUM;
                        w_acc_nxt     = '0;
                        w_cnt_nxt     = '0;
                        w_ovf_acc_nxt = 1'b0;
                        w_ovf_nxt     = 1'b0;
                    end
                end
                default: w_state_nxt = ST_ACCUM;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_ovf_acc <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sum     <= w_sum_nxt;
            r_ovf_acc <= w_ovf_acc_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 8x8 pipelined multiplier's 16-bit product stream.
- Sums COUNT consecutive valid products into one wide result, then presents that result on a valid/ready output handshake.
- Used for dot-product and MAC-style reductions.
- Upstream logic delays its valid flag to match the multiplier's 3-cycle latency and drives in_valid with it.

Parameters:
- COUNT, 8: products per result; legal range 1..255.
- ACC_W, 19: accumulator/result width; legal range 16..32. Default holds 8 x 0xFFFF without overflow.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous abort/flush of the current sum.
- in_valid, input, 1: m carries a valid product this cycle.
- in_ready, output, 1: block accepts a product this cycle.
- m, input, 16: unsigned product from the multiplier.
- out_valid, output, 1: sum holds a completed result.
- out_ready, input, 1: consumer accepts the result.
- sum, output, ACC_W: completed accumulated result.
- ovf, output, 1: overflow occurred during this result's accumulation.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - State=ACCUM; acc=0; cnt=0 (8-bit); sum=0; ovf=0; out_valid=0.
  - in_ready=1 after rst_n deasserts.
- Accept rule: a product is accepted on a clock edge where in_valid & in_ready.
- Arithmetic: m is zero-extended to ACC_W bits. acc_next = acc + m, computed with one extra carry bit.
- Overflow: carry out sets an internal ovf flag, sticky until the result is consumed.
- ACCUM state:
  - in_ready=1; out_valid=0.
  - On accept with cnt < COUNT-1: acc <= acc_next; cnt <= cnt+1.
  - On accept with cnt == COUNT-1: sum <= acc_next and ovf <= sticky flag OR'd with this carry; out_valid <= 1; state <= DONE.
- Latency: out_valid rises on the cycle after the COUNT-th accepted product.
- DONE state:
  - in_ready=0; in_valid is ignored and no product is lost or counted.
  - sum and ovf are held stable while out_valid=1 & out_ready=0.
  - On out_ready=1: out_valid <= 0; acc <= 0; cnt <= 0; ovf flag cleared; state <= ACCUM.
  - Throughput is one result per COUNT+1 cycles minimum.
- Output values after handshake: sum keeps its last value after the handshake; only out_valid qualifies it. ovf output is cleared together with out_valid.
- clear=1 has priority over everything in any state:
  - Next state ACCUM; acc=0; cnt=0; ovf=0; out_valid=0; sum unchanged.
  - A product presented in the same cycle is dropped, and in_ready stays 1 in ACCUM.
- COUNT=1: every accepted product goes straight to DONE; sum = zero-extended m.
- Gaps: in_valid gaps of any length are legal; cnt advances only on accepts.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SATURATE_EN.
- Defined: on carry out, acc/sum clamp to all-ones (2^ACC_W - 1) and stay clamped for the rest of the result. ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W. ovf is still set on carry out.

Test Plan:
- Full-scale sum: COUNT=8, ACC_W=19; 8 back-to-back accepts of m=0xFFFF -> out_valid 1 cycle after the 8th accept, sum=0x7FFF8, ovf=0.
- Overflow: COUNT=2, ACC_W=16; m=0xFFFF then 0x0002 -> without macro sum=0x0001, ovf=1; with macro sum=0xFFFF, ovf=1.
- Backpressure: result ready, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, sum/out_valid stable, cnt unchanged; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Clear mid-accumulation: 3 products of 0x0100, then clear=1 with in_valid=1 and m=0x0500, then m=1..8 -> sum=36 (0x24), ovf=0.
- Bubbles: COUNT=4; products 10,20,30,40 separated by 0-3 idle cycles -> sum=100 exactly once.
- Async reset in DONE: drop rst_n mid-cycle -> out_valid=0, sum=0, ovf=0 before the next clk edge; after release, 8 products of 1 -> sum=8.
